// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority vote, valid/ready output.
// Break detection is compiled in only when UART_RX_BREAK_DETECT_EN is defined.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Serin,
    output logic [DATA_BITS-1:0] DataOut,
    output logic                 Valid,
    input  logic                 Ready,
    output logic                 ParityErr,
    output logic                 FrameErr,
    output logic                 Overrun,
    output logic                 Busy,
    output logic                 SampleFlag,
    output logic                 Break
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_DELAY = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_DELAY  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST  = 1'(STOP_BITS - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_DATA     = 3'd2;
    localparam logic [2:0] ST_PARITY   = 3'd3;
    localparam logic [2:0] ST_STOP     = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;
    localparam logic [2:0] ST_BRK_WAIT = 3'd6;

    logic [2:0]           state;
    logic                 sync1, s, s_d1, s_d2;
    logic                 m, fall, tick;
    logic [CNT_W-1:0]     delay;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 frame_bad;
    logic                 perr_calc;
    logic                 is_break;
    logic                 deliver, load, drop, handshake;
    logic                 drop_pend;

    // NOTE: synchroniser flops reset to 1 so a reset release on an idle line never looks like a start edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync1 <= 1'b1;
            s     <= 1'b1;
            s_d1  <= 1'b1;
            s_d2  <= 1'b1;
        end else begin
            sync1 <= Serin;
            s     <= sync1;
            s_d1  <= s;
            s_d2  <= s_d1;
        end
    end

    assign m    = (s & s_d1) | (s & s_d2) | (s_d1 & s_d2);
    assign fall = !s && s_d1;
    assign tick = (delay == '0);

    assign Busy       = (state != ST_IDLE);
    assign SampleFlag = tick && (state == ST_START || state == ST_DATA ||
                                 state == ST_PARITY || state == ST_STOP);
    assign perr_calc  = (PARITY != 0) && (((^shreg) ^ par_bit) != (PARITY == 1));

    // NOTE: all sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= ST_IDLE;
            delay     <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            frame_bad <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    stop_idx  <= 1'b0;
                    frame_bad <= 1'b0;
                    par_bit   <= 1'b0;
                    if (fall) begin
                        state <= ST_START;
                        delay <= HALF_DELAY;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (!m) begin
                            state   <= ST_DATA;
                            delay   <= BIT_DELAY;
                            bit_idx <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        delay <= delay - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shreg[bit_idx] <= m;
                        delay          <= BIT_DELAY;
                        if (bit_idx == LAST_IDX) begin
                            state <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        delay <= delay - 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        par_bit <= m;
                        delay   <= BIT_DELAY;
                        state   <= ST_STOP;
                    end else begin
                        delay <= delay - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (!m) frame_bad <= 1'b1;
                        delay <= BIT_DELAY;
                        if (stop_idx == STOP_LAST) state <= ST_DONE;
                        else stop_idx <= 1'b1;
                    end else begin
                        delay <= delay - 1'b1;
                    end
                end
                ST_DONE:     state <= is_break ? ST_BRK_WAIT : ST_IDLE;
                ST_BRK_WAIT: if (s) state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
        end
    end

    assign deliver   = (state == ST_DONE) && !is_break;
    assign handshake = Valid && Ready;
    assign load      = deliver && (!Valid || Ready);
    assign drop      = deliver && Valid && !Ready;

    // A drop marks the held word; Overrun survives that word's handshake and clears on the next clean one.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            DataOut   <= '0;
            Valid     <= 1'b0;
            ParityErr <= 1'b0;
            FrameErr  <= 1'b0;
            Overrun   <= 1'b0;
            drop_pend <= 1'b0;
        end else begin
            if (load) begin
                DataOut   <= shreg;
                ParityErr <= perr_calc;
                FrameErr  <= frame_bad;
                Valid     <= 1'b1;
            end else if (handshake) begin
                Valid <= 1'b0;
            end

            if (drop) begin
                Overrun   <= 1'b1;
                drop_pend <= 1'b1;
            end else if (handshake) begin
                if (drop_pend) drop_pend <= 1'b0;
                else Overrun <= 1'b0;
            end
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    logic stop_high;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stop_high <= 1'b0;
            Break     <= 1'b0;
        end else begin
            if (state == ST_IDLE) stop_high <= 1'b0;
            else if (state == ST_STOP && tick && m) stop_high <= 1'b1;
            Break <= (state == ST_DONE) && is_break;
        end
    end

    assign is_break = (shreg == '0) && ((PARITY == 0) || !par_bit) && !stop_high;
`else
    assign is_break = 1'b0;
    assign Break    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: default, even-parity and two-stop-bit instances.
module tb_uart_rx_param;
    localparam int OS = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] serin = 3'b111;
    logic [2:0] ready = 3'b111;
    logic [7:0] dout0, dout1, dout2;
    logic [2:0] valid, perr, ferr, ovr, busy, sflag, brk;

    int   checks = 0;
    int   failures = 0;
    int   vcnt0 = 0;
    int   sfcnt0 = 0;
    int   brkcnt0 = 0;
    exp_t q0[$], q1[$], q2[$];

    always #5 clk = ~clk;

    uart_rx_param u_def (
        .Clk(clk), .Reset(rst_n), .Serin(serin[0]), .DataOut(dout0), .Valid(valid[0]),
        .Ready(ready[0]), .ParityErr(perr[0]), .FrameErr(ferr[0]), .Overrun(ovr[0]),
        .Busy(busy[0]), .SampleFlag(sflag[0]), .Break(brk[0])
    );

    uart_rx_param #(.PARITY(2)) u_par (
        .Clk(clk), .Reset(rst_n), .Serin(serin[1]), .DataOut(dout1), .Valid(valid[1]),
        .Ready(ready[1]), .ParityErr(perr[1]), .FrameErr(ferr[1]), .Overrun(ovr[1]),
        .Busy(busy[1]), .SampleFlag(sflag[1]), .Break(brk[1])
    );

    uart_rx_param #(.STOP_BITS(2)) u_stp (
        .Clk(clk), .Reset(rst_n), .Serin(serin[2]), .DataOut(dout2), .Valid(valid[2]),
        .Ready(ready[2]), .ParityErr(perr[2]), .FrameErr(ferr[2]), .Overrun(ovr[2]),
        .Busy(busy[2]), .SampleFlag(sflag[2]), .Break(brk[2])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic push(input int which, input exp_t e);
        case (which)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic scb(input int which, input exp_t got);
        exp_t e;
        bit   have;
        have = 1'b0;
        case (which)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            checks++;
            failures++;
            $display("FAIL scb%0d unexpected word got=%0h", which, got);
        end else begin
            check($sformatf("scb%0d word", which), 32'(got), 32'(e));
        end
    endtask

    // Monitors: compare each accepted word against the head of its queue.
    always @(negedge clk) if (rst_n && valid[0] && ready[0]) scb(0, {dout0, perr[0], ferr[0]});
    always @(negedge clk) if (rst_n && valid[1] && ready[1]) scb(1, {dout1, perr[1], ferr[1]});
    always @(negedge clk) if (rst_n && valid[2] && ready[2]) scb(2, {dout2, perr[2], ferr[2]});

    always @(negedge clk) begin
        if (valid[0]) vcnt0++;
        if (sflag[0]) sfcnt0++;
        if (brk[0])   brkcnt0++;
    end

    task automatic hold(input int which, input logic v, input int n);
        serin[which] = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int which, input logic [7:0] data, input bit has_par,
                              input logic par, input logic stop1, input bit has_stop2,
                              input logic stop2, input int glitch_bit);
        hold(which, 1'b0, OS);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_bit) begin
                hold(which, data[i], 8);
                hold(which, ~data[i], 1);
                hold(which, data[i], OS - 9);
            end else begin
                hold(which, data[i], OS);
            end
        end
        if (has_par) hold(which, par, OS);
        hold(which, stop1, OS);
        if (has_stop2) hold(which, stop2, OS);
        serin[which] = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int vbase, sbase, bbase, n;

        repeat (3) @(posedge clk);
        #1;
        check("rst valid", {29'd0, valid}, 0);
        check("rst dataout", dout0, 0);
        check("rst busy", {29'd0, busy}, 0);
        check("rst overrun", {29'd0, ovr}, 0);
        check("rst perr_ferr", {perr[0], ferr[0]}, 0);
        check("rst sampleflag", {29'd0, sflag}, 0);
        check("rst break", {29'd0, brk}, 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // 0xA5 8N1 with Ready high
        vbase = vcnt0;
        sbase = sfcnt0;
        push(0, '{data: 8'hA5, perr: 1'b0, ferr: 1'b0});
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        hold(0, 1'b1, 10);
        check("a5 valid cycles", vcnt0 - vbase, 1);
        check("a5 sampleflag pulses", sfcnt0 - sbase, 10);
        check("a5 busy idle", {31'd0, busy[0]}, 0);

        // even parity: wrong then correct parity bit
        push(1, '{data: 8'h07, perr: 1'b1, ferr: 1'b0});
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        hold(1, 1'b1, 4);
        push(1, '{data: 8'h07, perr: 1'b0, ferr: 1'b0});
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, -1);
        hold(1, 1'b1, 10);
        check("par valid low", {31'd0, valid[1]}, 0);

        // short low pulse is rejected
        vbase = vcnt0;
        hold(0, 1'b0, 5);
        serin[0] = 1'b1;
        n = 0;
        while (busy[0] === 1'b1 && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("pulse busy clears", {31'd0, busy[0]}, 0);
        hold(0, 1'b1, 20);
        check("pulse no valid", vcnt0 - vbase, 0);

        // single-cycle high glitch at the mid-bit of data bit 3
        push(0, '{data: 8'h00, perr: 1'b0, ferr: 1'b0});
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3);
        hold(0, 1'b1, 10);

        // overrun: two frames with Ready low, second is dropped
        ready[0] = 1'b0;
        push(0, '{data: 8'h11, perr: 1'b0, ferr: 1'b0});
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        hold(0, 1'b1, 4);
        check("ovr held data", dout0, 8'h11);
        check("ovr valid held", {31'd0, valid[0]}, 1);
        check("ovr set", {31'd0, ovr[0]}, 1);
        ready[0] = 1'b1;
        @(posedge clk);
        #1;
        ready[0] = 1'b0;
        check("ovr valid cleared", {31'd0, valid[0]}, 0);
        check("ovr sticky", {31'd0, ovr[0]}, 1);
        ready[0] = 1'b1;
        push(0, '{data: 8'h33, perr: 1'b0, ferr: 1'b0});
        send_frame(0, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        hold(0, 1'b1, 6);
        check("ovr cleared", {31'd0, ovr[0]}, 0);

        // two stop bits: second one low, then a clean frame
        push(2, '{data: 8'h3C, perr: 1'b0, ferr: 1'b1});
        send_frame(2, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        hold(2, 1'b1, 4);
        push(2, '{data: 8'hC3, perr: 1'b0, ferr: 1'b0});
        send_frame(2, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, -1);
        hold(2, 1'b1, 10);

`ifdef UART_RX_BREAK_DETECT_EN
        // line low for three frame times
        vbase = vcnt0;
        bbase = brkcnt0;
        hold(0, 1'b0, 3 * 10 * OS);
        hold(0, 1'b1, 20);
        check("break pulses", brkcnt0 - bbase, 1);
        check("break no valid", vcnt0 - vbase, 0);
        push(0, '{data: 8'h5A, perr: 1'b0, ferr: 1'b0});
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        hold(0, 1'b1, 10);
`else
        // all-zero frame is delivered as data 0 with a framing error
        bbase = brkcnt0;
        push(0, '{data: 8'h00, perr: 1'b0, ferr: 1'b1});
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        hold(0, 1'b1, 20);
        check("zero frame no break", brkcnt0 - bbase, 0);
`endif

        check("q0 drained", q0.size(), 0);
        check("q1 drained", q1.size(), 0);
        check("q2 drained", q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver in the ADC command path.
- Configurable data width, oversampling ratio, parity and stop bits.
- Input synchroniser and 3-sample majority-vote bit decision.
- Valid/Ready output handshake with overrun detection.
- Clk runs at OVERSAMPLE x baud. Sits between the board RX pin and the command decoder.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first
OVERSAMPLE, 16, Clk cycles per bit, even, legal 8..64
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
Clk  in  1  receiver clock, OVERSAMPLE x baud
Reset  in  1  asynchronous, active-low reset
Serin  in  1  asynchronous serial line, idle high
DataOut  out  DATA_BITS  received word, stable while Valid
Valid  out  1  word available
Ready  in  1  consumer accepts word when Valid && Ready
ParityErr  out  1  parity mismatch for word on DataOut, qualified by Valid
FrameErr  out  1  stop bit(s) low for word on DataOut, qualified by Valid
Overrun  out  1  sticky: a completed frame was dropped
Busy  out  1  high in every state except IDLE
SampleFlag  out  1  one-cycle pulse on each mid-bit decision (debug/scope)
Break  out  1  one-cycle break pulse (see Optional Feature)

Behaviour:
- Reset (asynchronous, active-low; clock Clk): all outputs 0, DataOut = 0, state IDLE, counters 0, synchroniser flops = 1.
- Synchronisation: Serin passes through 2 flops (s). Majority vote m = majority of the last 3 values of s.
- Mid-bit point: cycle OVERSAMPLE/2 - 1 of each bit period, counted from the start edge. The bit decision uses m at that cycle. SampleFlag pulses on that cycle.
- IDLE -> START on s falling (s = 0, previous s = 1). Load delay = OVERSAMPLE/2 - 1.
- START: decrement delay; at 0 evaluate m.
  - m = 0: go to DATA, delay = OVERSAMPLE - 1, bit index = 0.
  - m = 1: glitch; return to IDLE with no flag.
- DATA: at each delay = 0, shift m into bit[index] and reload delay = OVERSAMPLE - 1. After bit DATA_BITS-1, go to PARITY if PARITY != 0, else STOP.
- PARITY: sample m. perr = (XOR(data) ^ m) != (PARITY == 1). Go to STOP.
- STOP: sample each of the STOP_BITS stop bits. ferr = 1 if any sampled stop bit is 0. After the last stop sample, go to DONE.
- DONE (1 cycle), then IDLE. The next falling edge is accepted the cycle after DONE, so back-to-back frames are received.
- Delivery in DONE:
  - If !Valid, or Valid && Ready in the same cycle: load DataOut, ParityErr, FrameErr; Valid = 1 next cycle. This gives latency of 1 cycle after the last stop mid-bit decision plus the DONE cycle.
  - If Valid && !Ready: drop the new frame; Overrun = 1. Held data and flags are unchanged.
- Handshake:
  - Valid && Ready with no new frame completing: Valid = 0 next cycle.
  - DataOut, ParityErr and FrameErr hold while Valid = 1.
  - Overrun clears only on a Valid && Ready handshake in which no frame is dropped.
- ParityErr is always 0 when PARITY = 0.
- DATA_BITS < 9: DataOut bits are LSB-aligned; no padding.
- Reset mid-frame: immediate return to IDLE; any partial frame is discarded.

Optional Feature:
Macro: UART_RX_BREAK_DETECT_EN
- Defined: in DONE, if all data bits = 0, parity bit (if present) = 0 and all stop samples = 0:
  - no word is delivered (Valid unchanged, Overrun unaffected);
  - Break pulses for 1 cycle;
  - state goes to BRK_WAIT, which holds until s = 1, then returns to IDLE.
- Not defined: Break is tied to 0. An all-zero frame is delivered as data 0 with FrameErr = 1, and the block returns to IDLE. A continuing low line then restarts reception.

Test Plan:
1. Defaults, Ready = 1, send 0xA5 8N1 -> Valid for 1 cycle, DataOut = 0xA5, ParityErr = 0, FrameErr = 0; 10 SampleFlag pulses.
2. PARITY = 2, send 0x07 with parity bit 0 -> DataOut = 0x07, ParityErr = 1 (correct even parity bit is 1). Resend with parity 1 -> ParityErr = 0.
3. Low pulse of 5 Clk cycles on an idle line -> no Valid, no error, Busy returns to 0 within 8 cycles. A single-cycle high glitch at a data mid-bit is rejected by the majority vote (0x00 received intact).
4. Ready = 0, send 0x11 then 0x22 back-to-back -> DataOut stays 0x11, Overrun = 1. Ready = 1 for 1 cycle -> Valid = 0, Overrun stays 1. Next frame 0x33 with Ready high -> Overrun = 0.
5. STOP_BITS = 2, send 0x3C with second stop bit 0 -> DataOut = 0x3C, FrameErr = 1.
6. With UART_RX_BREAK_DETECT_EN, hold Serin low for 3 frame times -> Break pulses once, no Valid. Serin high, then send 0x5A -> received correctly.
